// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared RV32M constants for the EX-stage MDU issue controller and its neighbours.
package mdu_issue_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int WD_W   = 6;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  // Cycles from the MDU sampling start_i to raising ready_o.
  localparam int MDU_MUL_LATENCY = 1;
  localparam int MDU_DIV_LATENCY = 33;

  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl.sv
// EX-stage initiator for the RV32M multiply/divide unit: holds operands, drives the
// start/ready handshake, stalls EX, and absorbs flushes while the MDU cannot abort.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_req_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [DATA_W-1:0] ex_rs1_i,
  input  logic [DATA_W-1:0] ex_rs2_i,
  input  logic [RD_W-1:0]   ex_rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic [RD_W-1:0]   result_rd_o,
  output logic              error_o,
  output logic              mdu_start_o,
  output logic [DATA_W-1:0] mdu_operand_a_o,
  output logic [DATA_W-1:0] mdu_operand_b_o,
  output logic [2:0]        mdu_funct3_o,
  input  logic [DATA_W-1:0] mdu_result_i,
  input  logic              mdu_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_RELEASE
  } state_t;

  state_t            r_state;
  logic              r_start;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [2:0]        r_funct3;
  logic [RD_W-1:0]   r_rd;
  logic [DATA_W-1:0] r_result;
  logic [RD_W-1:0]   r_result_rd;
  logic              r_result_valid;
  logic              r_error;
  logic [WD_W-1:0]   r_wd;

  logic [WD_W:0]     w_wd_inc;
  logic              w_wd_fire;
  logic              w_accept;
  logic              w_stall;

  assign w_accept  = ex_req_i && !flush_i;
  // The watchdog fires on the cycle its count would reach TIMEOUT.
  assign w_wd_inc  = {1'b0, r_wd} + (WD_W + 1)'(1);
  assign w_wd_fire = (w_wd_inc >= (WD_W + 1)'(TIMEOUT));

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:    w_stall = w_accept;
      S_ISSUE:   w_stall = 1'b1;
      S_WAIT:    w_stall = 1'b1;
      S_DRAIN:   w_stall = ex_req_i;
      S_RELEASE: w_stall = 1'b0;
      default:   w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_start        <= 1'b0;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_funct3       <= '0;
      r_rd           <= '0;
      r_result       <= '0;
      r_result_rd    <= '0;
      r_result_valid <= 1'b0;
      r_error        <= 1'b0;
      r_wd           <= '0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Operands only change here, keeping the MDU result mux stable.
          if (w_accept) begin
            r_op_a   <= ex_rs1_i;
            r_op_b   <= ex_rs2_i;
            r_funct3 <= ex_funct3_i;
            r_rd     <= ex_rd_i;
            r_start  <= 1'b1;
            r_wd     <= '0;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Ready is still the idle-MDU ready here, so it is not a completion.
          r_state <= flush_i ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (flush_i) begin
            r_wd    <= w_wd_inc[WD_W-1:0];
            r_state <= S_DRAIN;
          end else if (mdu_ready_i) begin
            r_result       <= mdu_result_i;
            r_result_rd    <= r_rd;
            r_result_valid <= 1'b1;
            r_start        <= 1'b0;
            r_state        <= S_RELEASE;
          end else if (w_wd_fire) begin
            r_error        <= 1'b1;
            r_result       <= '0;
            r_result_rd    <= r_rd;
            r_result_valid <= 1'b1;
            r_start        <= 1'b0;
            r_state        <= S_RELEASE;
          end else begin
            r_wd <= w_wd_inc[WD_W-1:0];
          end
        end
        S_DRAIN: begin
          // A flushed operation still runs to completion; its result is dropped.
          if (mdu_ready_i) begin
            r_start <= 1'b0;
            r_state <= S_RELEASE;
          end else if (w_wd_fire) begin
            r_error <= 1'b1;
            r_start <= 1'b0;
            r_state <= S_RELEASE;
          end else begin
            r_wd <= w_wd_inc[WD_W-1:0];
          end
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_start <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall_o         = w_stall;
  assign result_valid_o  = r_result_valid;
  assign result_o        = r_result;
  assign result_rd_o     = r_result_rd;
  assign error_o         = r_error;
  assign mdu_start_o     = r_start;
  assign mdu_operand_a_o = r_op_a;
  assign mdu_operand_b_o = r_op_b;
  assign mdu_funct3_o    = r_funct3;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: behavioural MDU stub, stream timing model, corner sequences.
`timescale 1ns/1ps
module tb_mdu_issue_ctrl;
  import mdu_issue_ctrl_pkg::*;

  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_req;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        stall, result_valid, error, mdu_start;
  logic [31:0] result, mdu_a, mdu_b, mdu_result;
  logic [4:0]  result_rd;
  logic [2:0]  mdu_f3;
  logic        mdu_ready;
  logic        stuck_low;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_req_i(ex_req), .ex_funct3_i(ex_funct3), .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2),
    .ex_rd_i(ex_rd), .flush_i(flush),
    .stall_o(stall), .result_valid_o(result_valid), .result_o(result),
    .result_rd_o(result_rd), .error_o(error),
    .mdu_start_o(mdu_start), .mdu_operand_a_o(mdu_a), .mdu_operand_b_o(mdu_b),
    .mdu_funct3_o(mdu_f3), .mdu_result_i(mdu_result), .mdu_ready_i(mdu_ready)
  );

  // RV32M arithmetic from the ISA definition.
  function automatic logic [31:0] mdu_ref(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      FUNCT3_MUL:    begin p = {32'b0, a} * {32'b0, b};               return p[31:0];  end
      FUNCT3_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};   return p[63:32]; end
      FUNCT3_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b};         return p[63:32]; end
      FUNCT3_MULHU:  begin p = {32'b0, a} * {32'b0, b};               return p[63:32]; end
      FUNCT3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      FUNCT3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      FUNCT3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f3);
    return is_div(f3) ? MDU_DIV_LATENCY : MDU_MUL_LATENCY;
  endfunction

  // MDU stub: idle -> busy for its latency after sampling start -> done until start drops.
  int m_state;
  int m_cnt;
  always @(posedge clk) begin
    if (rst) begin
      m_state <= 0;
      m_cnt   <= 0;
    end else begin
      case (m_state)
        0: if (mdu_start) begin
          if (lat_of(mdu_f3) == 1) m_state <= 2;
          else begin m_state <= 1; m_cnt <= lat_of(mdu_f3) - 1; end
        end
        1: if (m_cnt == 1) m_state <= 2; else m_cnt <= m_cnt - 1;
        default: if (!mdu_start) m_state <= 0;
      endcase
    end
  end
  assign mdu_ready  = (m_state != 1) && !stuck_low;
  assign mdu_result = mdu_ref(mdu_f3, mdu_a, mdu_b);

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag, input int cyc);
    chk({tag, " start"},  cyc, 32'(mdu_start), 0);
    chk({tag, " valid"},  cyc, 32'(result_valid), 0);
    chk({tag, " result"}, cyc, result, 0);
    chk({tag, " rd"},     cyc, 32'(result_rd), 0);
    chk({tag, " error"},  cyc, 32'(error), 0);
    chk({tag, " op_a"},   cyc, mdu_a, 0);
    chk({tag, " op_b"},   cyc, mdu_b, 0);
    chk({tag, " f3"},     cyc, 32'(mdu_f3), 0);
    chk({tag, " stall"},  cyc, 32'(stall), 0);
  endtask

  task automatic drive(input logic req, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    ex_req = req; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t ops[$];

  // EX presents each op until the cycle stall drops; op k+1 follows immediately.
  // Acceptance k+1 = acceptance k + latency + 3; pulse at acceptance + latency + 2.
  task automatic run_stream(input string tag);
    int t[$];
    int tk;
    int k;
    int rel;
    int lat;
    tk = 0;
    foreach (ops[i]) begin
      t.push_back(tk);
      tk += lat_of(ops[i].f3) + 3;
    end
    for (int c = 0; c < tk + 2; c++) begin
      @(negedge clk);
      k = -1;
      foreach (ops[i]) if (c >= t[i] && c < t[i] + lat_of(ops[i].f3) + 3) k = i;
      if (k >= 0) drive(1'b1, ops[k].f3, ops[k].a, ops[k].b, ops[k].rd);
      else        drive(1'b0, 3'b0, 32'h0, 32'h0, 5'h0);
      #1;
      if (k < 0) begin
        chk({tag, " idle stall"}, c, 32'(stall), 0);
        chk({tag, " idle start"}, c, 32'(mdu_start), 0);
        chk({tag, " idle valid"}, c, 32'(result_valid), 0);
      end else begin
        rel = c - t[k];
        lat = lat_of(ops[k].f3);
        chk({tag, " stall"}, c, 32'(stall), 32'(rel <= lat + 1));
        chk({tag, " start"}, c, 32'(mdu_start), 32'(rel >= 1 && rel <= lat + 1));
        chk({tag, " valid"}, c, 32'(result_valid), 32'(rel == lat + 2));
        if (rel >= 1 && rel <= lat + 1) begin
          chk({tag, " op_a"}, c, mdu_a, ops[k].a);
          chk({tag, " op_b"}, c, mdu_b, ops[k].b);
          chk({tag, " f3"},   c, 32'(mdu_f3), 32'(ops[k].f3));
        end
        if (rel == lat + 2) begin
          chk({tag, " result"}, c, result, ops[k].exp);
          chk({tag, " rd"},     c, 32'(result_rd), 32'(ops[k].rd));
        end
      end
    end
  endtask

  initial begin
    vec_t tbl[10];
    vec_t v;
    stuck_low = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    drive(1'b0, 3'b0, 32'h0, 32'h0, 5'h0);

    // Reset state
    repeat (3) @(negedge clk);
    chk_zero("reset", 0);
    rst = 1'b0;

    // Directed vectors, issued back to back
    tbl[0] = '{FUNCT3_MUL,    32'd7,          32'd6,          5'd5,  32'd42};
    tbl[1] = '{FUNCT3_DIV,    32'hFFFF_FFEC,  32'd3,          5'd10, 32'hFFFF_FFFA};
    tbl[2] = '{FUNCT3_REM,    32'hFFFF_FFEC,  32'd3,          5'd11, 32'hFFFF_FFFE};
    tbl[3] = '{FUNCT3_DIVU,   32'h1234_5678,  32'd0,          5'd3,  32'hFFFF_FFFF};
    tbl[4] = '{FUNCT3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd4,  32'h8000_0000};
    tbl[5] = '{FUNCT3_MULH,   32'hFFFF_FFFF,  32'd2,          5'd6,  32'hFFFF_FFFF};
    tbl[6] = '{FUNCT3_MUL,    32'hFFFF_FFFF,  32'd2,          5'd7,  32'hFFFF_FFFE};
    tbl[7] = '{FUNCT3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd8,  32'hFFFF_FFFE};
    tbl[8] = '{FUNCT3_REMU,   32'd17,         32'd5,          5'd9,  32'd2};
    tbl[9] = '{FUNCT3_MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd12, 32'hFFFF_FFFF};
    ops.delete();
    for (int i = 0; i < 10; i++) ops.push_back(tbl[i]);
    run_stream("table");

    // Randomised stream against the arithmetic model
    ops.delete();
    for (int i = 0; i < 16; i++) begin
      v.f3 = 3'($urandom_range(0, 7));
      v.a  = $urandom;
      v.b  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      v.rd = 5'($urandom_range(1, 31));
      v.exp = mdu_ref(v.f3, v.a, v.b);
      ops.push_back(v);
    end
    run_stream("rand");

    // DIV flushed at T+10 while a younger MUL waits from T+12
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      flush = (c == 10);
      if (c <= 10)      drive(1'b1, FUNCT3_DIV, 32'd100, 32'd7, 5'd13);
      else if (c == 11) drive(1'b0, 3'b0, 32'h0, 32'h0, 5'h0);
      else if (c <= 39) drive(1'b1, FUNCT3_MUL, 32'd5, 32'd9, 5'd14);
      else              drive(1'b0, 3'b0, 32'h0, 32'h0, 5'h0);
      #1;
      chk("flush valid", c, 32'(result_valid), 32'(c == 39));
      chk("flush start", c, 32'(mdu_start), 32'((c >= 1 && c <= 34) || (c >= 37 && c <= 38)));
      chk("flush stall", c, 32'(stall),
          32'((c <= 10) || (c >= 12 && c <= 34) || (c >= 36 && c <= 38)));
      if (c >= 1 && c <= 34) chk("flush op_a held", c, mdu_a, 32'd100);
      if (c == 39) begin
        chk("flush mul result", c, result, 32'd45);
        chk("flush mul rd", c, 32'(result_rd), 32'd14);
      end
    end
    flush = 1'b0;

    // Watchdog with ready stuck low
    stuck_low = 1'b1;
    for (int c = 0; c < TIMEOUT + 5; c++) begin
      @(negedge clk);
      if (c <= TIMEOUT + 2) drive(1'b1, FUNCT3_MUL, 32'd3, 32'd4, 5'd9);
      else                  drive(1'b0, 3'b0, 32'h0, 32'h0, 5'h0);
      #1;
      chk("wd valid", c, 32'(result_valid), 32'(c == TIMEOUT + 2));
      chk("wd error", c, 32'(error), 32'(c >= TIMEOUT + 2));
      chk("wd start", c, 32'(mdu_start), 32'(c >= 1 && c <= TIMEOUT + 1));
      if (c == TIMEOUT + 2) begin
        chk("wd result", c, result, 32'h0);
        chk("wd rd", c, 32'(result_rd), 32'd9);
      end
    end
    stuck_low = 1'b0;

    // Reset mid-DIV, then a fresh MUL
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rst = (c == 5);
      if (c <= 4)      drive(1'b1, FUNCT3_DIV, 32'd99, 32'd3, 5'd15);
      else if (c <= 6) drive(1'b0, 3'b0, 32'h0, 32'h0, 5'h0);
      else if (c <= 10) drive(1'b1, FUNCT3_MUL, 32'd7, 32'd6, 5'd16);
      else             drive(1'b0, 3'b0, 32'h0, 32'h0, 5'h0);
      #1;
      if (c == 3) chk("rst pre start", c, 32'(mdu_start), 1);
      if (c == 3) chk("rst pre error", c, 32'(error), 1);
      if (c == 6) chk_zero("rst", c);
      if (c == 7) chk("rst accept stall", c, 32'(stall), 1);
      if (c >= 6) chk("rst valid", c, 32'(result_valid), 32'(c == 10));
      if (c == 10) begin
        chk("rst mul result", c, result, 32'd42);
        chk("rst mul rd", c, 32'(result_rd), 32'd16);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_issue_ctrl.md
# mdu_issue_ctrl

EX-stage initiator for the RV32M multiply/divide unit (`mult_div_unit`). It accepts a decoded M-extension instruction from EX, latches and holds its operands, and drives the start/ready handshake. It stalls the pipeline until the result is captured and returns the result with its destination register for writeback. It absorbs pipeline flushes that arrive while the non-abortable MDU is mid-operation.

## Interface
- `TIMEOUT`, 40: cycles allowed in S_WAIT/S_DRAIN without `mdu_ready_i` before the watchdog fires.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ex_req_i`  in  1  EX holds a valid M-extension instruction.
- `ex_funct3_i`  in  3  RV32M funct3.
- `ex_rs1_i`, `ex_rs2_i`  in  32  source operand values.
- `ex_rd_i`  in  5  destination register.
- `flush_i`  in  1  kill the instruction currently in EX.
- `stall_o`  out  1  hold the EX stage and everything upstream.
- `result_valid_o`  out  1  one-cycle pulse; `result_o` and `result_rd_o` are valid.
- `result_o`  out  32  captured MDU result.
- `result_rd_o`  out  5  destination of `result_o`.
- `error_o`  out  1  sticky watchdog error.
- `mdu_start_o`  out  1  MDU `start_i`.
- `mdu_operand_a_o`, `mdu_operand_b_o`  out  32  MDU operands.
- `mdu_funct3_o`  out  3  MDU funct3.
- `mdu_result_i`  in  32  MDU `result_o`. It is combinational from the MDU's funct3 and operands.
- `mdu_ready_i`  in  1  MDU `ready_o`. It is also high while the MDU is idle.

## Operation
States: S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_RELEASE.

- **S_IDLE:** if `ex_req_i && !flush_i`: latch rs1, rs2, funct3 and rd into the `mdu_*` output registers, then go to S_ISSUE. `stall_o = ex_req_i && !flush_i`.
- **S_ISSUE:** `mdu_start_o = 1`. Ignore `mdu_ready_i`, because the MDU is still idle and reports ready. Go to S_DRAIN if `flush_i`, else S_WAIT. `stall_o = 1`.
- **S_WAIT:** `mdu_start_o = 1`.
  - If `flush_i`: go to S_DRAIN. A flush in the same cycle as ready takes priority; the result is discarded.
  - Else if `mdu_ready_i`: capture `mdu_result_i` into `result_o`, then go to S_RELEASE with a result pulse pending.
  - `stall_o = 1`.
- **S_DRAIN:** `mdu_start_o = 1`, operands held. On `mdu_ready_i`: go to S_RELEASE with no result pulse. `stall_o = ex_req_i`, so a younger request waits for the drain to finish.
- **S_RELEASE:** `mdu_start_o = 0` for exactly one cycle so the MDU returns from DONE to IDLE.
  - `result_valid_o = 1` if the pulse is pending. `stall_o = 0` so EX advances with the result.
  - `ex_req_i` is ignored in this state, because it still belongs to the completed instruction.
  - Always go to S_IDLE.
- **Operand stability:** `mdu_operand_*_o` and `mdu_funct3_o` change only on acceptance in S_IDLE. This keeps the MDU's combinational result mux stable.
- **Watchdog:** a 6-bit counter clears on entry to S_ISSUE and increments in S_WAIT/S_DRAIN. When it reaches `TIMEOUT`:
  - set `error_o`, which stays set until `rst`;
  - go to S_RELEASE;
  - from S_WAIT, pulse with `result_o = 0`; from S_DRAIN, no pulse.
- **Reset:** state goes to S_IDLE. Every output and register is 0. The MDU shares `rst`, so no drain is needed.

## Timing
- Request seen in S_IDLE at cycle T:
  - `mdu_start_o` high T+1 to T+2 for multiply, T+1 to T+34 for divide/remainder;
  - `result_valid_o` pulse at T+3 for multiply, T+35 for divide (MDU divide latency is 33 cycles after start).
- `stall_o` is high from T through the last S_WAIT cycle and low in the S_RELEASE cycle.
- Back-to-back issue: the next request is accepted in S_IDLE at T+4 for multiply, T+36 for divide.
- Flush in S_ISSUE/S_WAIT: `mdu_start_o` stays held until `mdu_ready_i`, then one S_RELEASE cycle. No `result_valid_o`.
- Results are registered. `result_o` holds its value until the next capture.

## Structure
- FUNCT3 codes live in the shared `definitions.sv` and are reused. Add `MDU_MUL_LATENCY` (1) and `MDU_DIV_LATENCY` (33) there for the bench.
- The state enum is local to the block.
- No sub-module. The block is instantiated in EX beside `mult_div_unit`, wired port-to-port.

## Test plan
- MUL, rs1=7, rs2=6 at T -> `stall_o` high T..T+2, `result_valid_o` at T+3, `result_o`=42, `result_rd_o`=rd.
- DIV rs1=0xFFFFFFEC (-20), rs2=3 -> 0xFFFFFFFA at T+35. Then REM with the same operands accepted at T+36 -> 0xFFFFFFFE at T+71.
- DIVU by 0 -> 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. Both with correct latency.
- DIV at T, `flush_i` at T+10, new MUL request from T+12:
  - no result pulse for the DIV;
  - `mdu_start_o` held through T+34, low at T+35;
  - MUL accepted at T+36, result at T+39.
- MULH 0xFFFFFFFF x 2, then MUL with the same operands back-to-back -> 0xFFFFFFFF at T+3, 0xFFFFFFFE at T+7. Check `mdu_operand_*_o` is stable while start is high.
- Two failure cases:
  - `rst` at T+5 mid-DIV -> all outputs 0 on the next edge, and a new request is accepted after `rst` deasserts.
  - Stub MDU with ready stuck low -> `error_o` and a result pulse with `result_o` = 0 at T+2+`TIMEOUT`.
